// File: rtl/soc_system_gpio_in_capture.sv
// Avalon-MM input PIO: synchronizes an external WIDTH-bit port, optionally
// debounces it, latches per-bit edge events into a write-1-to-clear capture
// register and drives a level interrupt for the enabled capture bits.
module soc_system_gpio_in_capture #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int ARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES + 1);
   localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

   logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
   logic [WIDTH-1:0] s_lvl;
   logic [WIDTH-1:0] stable_p1;
   logic [WIDTH-1:0] prev_p2;
   logic [ARM_W-1:0] arm_cnt;
   logic             armed;

   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] edgetype;

   logic             wr_en;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] ev;
   logic             unused_wd;

   assign wr_en     = chipselect && !write_n;
   assign clr       = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
   assign s_lvl     = sync_p0[SYNC_STAGES-1];
   assign unused_wd = ^writedata;

   // Stage p0: metastability chain on the asynchronous inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
      end else begin
         sync_p0[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
      end
   end

   // Arming: let the chain and the stable/prev pair fill before edges count;
   // armed is registered one cycle after the count so prev has caught up.
   always_ff @(posedge clk) begin
      if (reset) begin
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         if (arm_cnt != ARM_LAST) arm_cnt <= arm_cnt + ARM_ONE;
         armed <= armed | (arm_cnt == ARM_LAST);
      end
   end

   // Stage p1: accepted (debounced) level
   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
         // Bypass: accepted level follows the synchronizer output directly
         always_ff @(posedge clk) begin
            if (reset) stable_p1 <= '0;
            else       stable_p1 <= s_lvl;
         end
      end else begin : g_deb
         localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         localparam logic [CNT_W-1:0] DEB_ONE  = CNT_W'(1);
         logic [CNT_W-1:0] deb_cnt [WIDTH];

         // Per-bit debounce: accept a new level only after it has differed
         // from the accepted level for DEBOUNCE_CYCLES consecutive cycles
         always_ff @(posedge clk) begin
            if (reset) begin
               stable_p1 <= '0;
               for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
            end else if (!armed) begin
               stable_p1 <= s_lvl;
               for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (s_lvl[i] == stable_p1[i]) begin
                     deb_cnt[i] <= '0;
                  end else if (deb_cnt[i] == DEB_LAST) begin
                     stable_p1[i] <= s_lvl[i];
                     deb_cnt[i]   <= '0;
                  end else begin
                     deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                  end
               end
            end
         end
      end
   endgenerate

   assign rise = stable_p1 & ~prev_p2;
   assign fall = ~stable_p1 & prev_p2;
   assign ev   = (edgetype & fall) | (~edgetype & rise);

   // Stage p2: previous level, control registers and edge capture (set wins over clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_p2  <= '0;
         irqmask  <= '0;
         edgecap  <= '0;
         edgetype <= '0;
      end else begin
         prev_p2 <= stable_p1;
         if (wr_en && address == 2'd1) irqmask  <= writedata[WIDTH-1:0];
         if (wr_en && address == 2'd3) edgetype <= writedata[WIDTH-1:0];
         edgecap <= (edgecap & ~clr) | (armed ? ev : '0);
      end
   end

   // Zero-wait-state read mux; unused upper bits read as zero
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = stable_p1;
         2'd1:    readdata[WIDTH-1:0] = irqmask;
         2'd2:    readdata[WIDTH-1:0] = edgecap;
         default: readdata[WIDTH-1:0] = edgetype;
      endcase
   end

   assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_soc_system_gpio_in_capture.sv
// Bench for soc_system_gpio_in_capture: one instance with the debouncer
// bypassed and one with DEBOUNCE_CYCLES=4, sharing clock, reset and bus.
`timescale 1ns/1ps
module tb_soc_system_gpio_in_capture;
   localparam int W = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] rdata0, rdata4;
   logic [W-1:0] in0 = '0, in4 = '0;
   logic        irq0, irq4;

   always #5 clk = ~clk;

   soc_system_gpio_in_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rdata0),
      .in_port(in0), .irq(irq0));

   soc_system_gpio_in_capture #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rdata4),
      .in_port(in4), .irq(irq4));

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   typedef struct {
      logic [1:0]  waddr;
      logic [31:0] wdata;
      logic [1:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[7];
   int   total = 0;
   int   bad   = 0;

   task automatic push(input string n, input logic [31:0] e);
      sb_t it;
      it.name = n;
      it.exp  = e;
      sb_q.push_back(it);
   endtask

   task automatic pop_check(input logic [31:0] act);
      sb_t it;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty actual=%h", act);
      end else begin
         it = sb_q.pop_front();
         if (act !== it.exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", it.name, act, it.exp);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d4);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d0 = rdata0;
      d4 = rdata4;
      chipselect = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic chk0(input string n, input logic [1:0] a, input logic [31:0] e);
      logic [31:0] d0, d4;
      push(n, e);
      rd(a, d0, d4);
      pop_check(d0);
   endtask

   task automatic chk4(input string n, input logic [1:0] a, input logic [31:0] e);
      logic [31:0] d0, d4;
      push(n, e);
      rd(a, d0, d4);
      pop_check(d4);
   endtask

   task automatic chk_irq0(input string n, input logic e);
      push(n, {31'd0, e});
      pop_check({31'd0, irq0});
   endtask

   initial begin
      logic [31:0] d0, d4;

      vecs[0] = '{2'd1, 32'h0000_00A5, 2'd1, 32'h0000_00A5};
      vecs[1] = '{2'd3, 32'h0000_003C, 2'd3, 32'h0000_003C};
      vecs[2] = '{2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_00FF};
      vecs[3] = '{2'd0, 32'h0000_00FF, 2'd0, 32'h0000_0000};
      vecs[4] = '{2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
      vecs[5] = '{2'd3, 32'h0000_0000, 2'd3, 32'h0000_0000};
      vecs[6] = '{2'd1, 32'h0000_0004, 2'd1, 32'h0000_0004};

      // Reset with inputs already high
      in0 = 8'hFF;
      in4 = 8'hFF;
      tick(3);
      for (int a = 0; a < 4; a++) chk0($sformatf("reset_reg%0d", a), 2'(a), 32'd0);
      chk_irq0("reset_irq", 1'b0);

      reset = 1'b0;
      tick(8);
      chk0("armed_data", 2'd0, 32'h0000_00FF);
      chk0("armed_edgecap", 2'd2, 32'd0);
      chk_irq0("armed_irq", 1'b0);
      chk4("armed_data_deb", 2'd0, 32'h0000_00FF);
      chk4("armed_edgecap_deb", 2'd2, 32'd0);

      reset = 1'b1;
      in0   = '0;
      in4   = '0;
      tick(2);
      reset = 1'b0;
      tick(8);

      // Register access vectors
      for (int v = 0; v < 7; v++) begin
         push($sformatf("vec%0d", v), vecs[v].exp);
         wr(vecs[v].waddr, vecs[v].wdata);
         rd(vecs[v].raddr, d0, d4);
         pop_check(d0);
      end

      // Bypass latency: DATA 3 cycles after in_port, EDGECAP one more
      in0 = 8'h05;
      tick(2);
      chk0("lat_data_early", 2'd0, 32'h0000_0000);
      tick(1);
      chk0("lat_data", 2'd0, 32'h0000_0005);
      chk0("lat_edgecap_early", 2'd2, 32'h0000_0000);
      tick(1);
      chk0("lat_edgecap", 2'd2, 32'h0000_0005);
      chk_irq0("lat_irq", 1'b1);

      // Write-1-to-clear
      wr(2'd2, 32'h0000_0004);
      chk0("w1c_edgecap", 2'd2, 32'h0000_0001);
      chk_irq0("w1c_irq", 1'b0);

      // Falling edge with rising type captures nothing
      in0 = 8'h04;
      tick(6);
      chk0("fall_ignored", 2'd2, 32'h0000_0001);

      // Clear and new rising event on bit 0 in the same cycle: set wins
      in0 = 8'h05;
      tick(3);
      wr(2'd2, 32'h0000_0001);
      chk0("set_wins", 2'd2, 32'h0000_0001);
      tick(1);
      chk0("set_wins_hold", 2'd2, 32'h0000_0001);
      wr(2'd2, 32'h0000_00FF);
      chk0("clear_all", 2'd2, 32'h0000_0000);

      // Falling-edge type on bit 0
      wr(2'd3, 32'h0000_0001);
      in0 = 8'h04;
      tick(5);
      chk0("falltype_cap", 2'd2, 32'h0000_0001);
      chk_irq0("falltype_masked_irq", 1'b0);
      wr(2'd1, 32'h0000_0001);
      chk_irq0("mask_write_irq", 1'b1);
      wr(2'd1, 32'h0000_0004);
      wr(2'd2, 32'h0000_00FF);
      chk0("falltype_clear", 2'd2, 32'h0000_0000);
      in0 = 8'h05;
      tick(5);
      chk0("falltype_rise_ignored", 2'd2, 32'h0000_0000);

      // Debouncer: a 3-cycle pulse is rejected
      in4 = 8'h02;
      tick(3);
      in4 = 8'h00;
      tick(10);
      chk4("deb_pulse_data", 2'd0, 32'h0000_0000);
      chk4("deb_pulse_edgecap", 2'd2, 32'h0000_0000);

      // Debouncer: a sustained level is accepted
      in4 = 8'h02;
      tick(5);
      chk4("deb_hold_early", 2'd0, 32'h0000_0000);
      tick(2);
      chk4("deb_hold_data", 2'd0, 32'h0000_0002);
      tick(1);
      chk4("deb_hold_edgecap", 2'd2, 32'h0000_0002);

      // Fill EDGECAP, then reset mid-operation
      wr(2'd3, 32'h0000_0000);
      in0 = 8'h00;
      tick(6);
      wr(2'd2, 32'h0000_00FF);
      in0 = 8'hFF;
      tick(6);
      wr(2'd1, 32'h0000_00FF);
      chk0("full_edgecap", 2'd2, 32'h0000_00FF);
      chk_irq0("full_irq", 1'b1);

      reset = 1'b1;
      tick(1);
      for (int a = 0; a < 4; a++) chk0($sformatf("midreset_reg%0d", a), 2'(a), 32'd0);
      chk_irq0("midreset_irq", 1'b0);
      chk4("midreset_edgecap_deb", 2'd2, 32'd0);
      reset = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
